// File: rtl/dest_reg_scoreboard_if.sv
// Issue / write-back bus of the destination-register scoreboard.
//   master : decode/issue side; drives the issue and write-back requests,
//            receives stall and the scoreboard status.
//   slave  : the scoreboard itself.
// Signals
//   issue_valid, issue_wr, issue_dst[AW], src1[AW], src2[AW]  issue request
//   wb_valid, wb_dst[AW]                                     write-back event
//   stall                 issue not accepted this cycle (combinational)
//   busy_mask[2**AW]      bit r set while register r has a write pending
//   inflight[AW+CNT_W]    total outstanding writes
//   err                   sticky illegal-writeback flag
interface dest_reg_scoreboard_if #(
    parameter int AW    = 5,
    parameter int CNT_W = 2
);
    logic                  issue_valid;
    logic                  issue_wr;
    logic [AW-1:0]         issue_dst;
    logic [AW-1:0]         src1;
    logic [AW-1:0]         src2;
    logic                  wb_valid;
    logic [AW-1:0]         wb_dst;
    logic                  stall;
    logic [2**AW-1:0]      busy_mask;
    logic [AW+CNT_W-1:0]   inflight;
    logic                  err;

    modport master (
        output issue_valid, issue_wr, issue_dst, src1, src2, wb_valid, wb_dst,
        input  stall, busy_mask, inflight, err
    );

    modport slave (
        input  issue_valid, issue_wr, issue_dst, src1, src2, wb_valid, wb_dst,
        output stall, busy_mask, inflight, err
    );
endinterface

// File: rtl/dest_reg_scoreboard.sv
// Destination-register scoreboard: one saturating outstanding-write counter
// per GPR. Issue of a register-writing instruction increments the counter of
// its destination, write-back decrements it. Issue stalls while a source has
// a pending write or the destination counter is at its maximum.
// Register 0 is never tracked.
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset; clears all pending state
//   bus     dest_reg_scoreboard_if.slave (issue, write-back, status)
// Configuration
//   SCB_WB_BYPASS_EN  when defined, a source whose only pending write is being
//                     written back this cycle does not stall (register file
//                     forwards the data). Counters, full check and err are
//                     unaffected.
module dest_reg_scoreboard #(
    parameter int AW    = 5,
    parameter int CNT_W = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dest_reg_scoreboard_if.slave   bus
);

    localparam int              NREG    = 2**AW;
    localparam int              IW      = AW + CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef SCB_WB_BYPASS_EN
    localparam bit WB_BYPASS = 1'b1;
`else
    localparam bit WB_BYPASS = 1'b0;
`endif

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [NREG-1:0]  busy_mask_q, busy_mask_d;
    logic [IW-1:0]    inflight_q, inflight_d;
    logic             err_q, err_d;

    logic hazard1, hazard2, full, stall_c, accept;
    logic inc, dec, wb_illegal;

    // A source is a hazard while it has a pending write, unless (bypass build)
    // its last pending write is retiring this very cycle.
    function automatic logic hazard(input logic [AW-1:0]    s,
                                    input logic [CNT_W-1:0] c,
                                    input logic             wb_hit);
        return (s != '0) && (c != '0) && !(WB_BYPASS && wb_hit && (c == CNT_ONE));
    endfunction

    always_comb begin
        hazard1 = hazard(bus.src1, cnt_q[bus.src1],
                         bus.wb_valid && (bus.wb_dst == bus.src1));
        hazard2 = hazard(bus.src2, cnt_q[bus.src2],
                         bus.wb_valid && (bus.wb_dst == bus.src2));
        full    = bus.issue_wr && (bus.issue_dst != '0) &&
                  (cnt_q[bus.issue_dst] == CNT_MAX);
        stall_c = bus.issue_valid && (hazard1 || hazard2 || full);
        accept  = bus.issue_valid && !stall_c;
    end

    // NOTE: every comb output gets a default before any conditional update so
    // no path leaves a signal unassigned (which would infer a latch).
    always_comb begin
        cnt_d       = cnt_q;
        err_d       = err_q;
        inc         = accept && bus.issue_wr && (bus.issue_dst != '0);
        dec         = bus.wb_valid && (bus.wb_dst != '0) && (cnt_q[bus.wb_dst] != '0);
        wb_illegal  = bus.wb_valid && (bus.wb_dst != '0) && (cnt_q[bus.wb_dst] == '0);

        if (wb_illegal) err_d = 1'b1;
        // Applied in sequence on cnt_d so inc and dec on the same register
        // cancel. inc never hits CNT_MAX (full stall), dec never goes below 0.
        if (inc) cnt_d[bus.issue_dst] = cnt_d[bus.issue_dst] + CNT_ONE;
        if (dec) cnt_d[bus.wb_dst]    = cnt_d[bus.wb_dst] - CNT_ONE;

        inflight_d = inflight_q + IW'(inc) - IW'(dec);

        busy_mask_d = '0;
        for (int r = 1; r < NREG; r++) begin
            busy_mask_d[r] = (cnt_d[r] != '0);
        end
    end

    // NOTE: the counter array is a bank of flops, not a RAM, and is cleared on
    // reset because reset must drop every pending write at once.
    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
            busy_mask_q <= '0;
            inflight_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            busy_mask_q <= busy_mask_d;
            inflight_q  <= inflight_d;
            err_q       <= err_d;
        end
    end

    assign bus.stall     = stall_c;
    assign bus.busy_mask = busy_mask_q;
    assign bus.inflight  = inflight_q;
    assign bus.err       = err_q;

endmodule
